// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by fetch, decode and the hazard unit.
package fetch_stage_pkg;

    // Opcode field position and the halt opcode.
    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam logic [3:0] OP_HALT = 4'b0000;

    // Opcode 0001 with bit15 clear: decode treats this as a harmless no-op.
    localparam logic [15:0] BUBBLE_INST = 16'h1000;

    typedef enum logic [0:0] {
        FS_RUN,
        FS_HALTED
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[OP_MSB:OP_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface fetch_stage_if;

    logic [15:0] imem_addr;
    logic [15:0] imem_data;

    modport master (
        output imem_addr,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        output imem_data
    );

endinterface

// File: rtl/fetch_perf_counters.sv
// Fetch and bubble event counters; both clear on reset and wrap at 2^32.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_ev,
    input  logic        bubble_ev,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    logic [31:0] fetch_q;
    logic [31:0] bubble_q;

    // Count one per qualifying edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q  <= 32'd0;
            bubble_q <= 32'd0;
        end else begin
            if (fetch_ev) begin
                fetch_q <= fetch_q + 32'd1;
            end
            if (bubble_ev) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_q;
    assign bubble_count = bubble_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, holds the IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [15:0]   redirect_pc,
    fetch_stage_if.master imem,
    output logic [15:0]   PC,
    output logic [15:0]   PCPlus1,
    output logic [15:0]   inst,
    output logic          inst_valid,
    output logic          halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   fetch_count,
    output logic [31:0]   bubble_count
`endif
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [15:0] pc_q;
    logic [15:0] pc_inc;
    logic [15:0] ifid_pc_q;
    logic [15:0] ifid_pc1_q;
    logic [15:0] ifid_inst_q;
    logic        ifid_valid_q;
    logic        fetch_en;

    assign pc_inc = pc_q + 16'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: redirect always resumes RUN; a fetched halt parks the stage.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FS_RUN;
        end else if (!stall && state_q == FS_RUN && is_halt(imem.imem_data)) begin
            state_d = FS_HALTED;
        end
    end

    // FSM outputs.
    always_comb begin
        halted   = (state_q == FS_HALTED);
        fetch_en = (state_q == FS_RUN) && !stall && !redirect_valid;
    end

    // PC and IF/ID register; a halt is latched but the PC stays on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= RESET_PC;
            ifid_pc1_q   <= RESET_PC + 16'd1;
            ifid_inst_q  <= BUBBLE_INST;
            ifid_valid_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q         <= redirect_pc;
            ifid_inst_q  <= BUBBLE_INST;
            ifid_valid_q <= 1'b0;
        end else if (fetch_en) begin
            ifid_pc_q    <= pc_q;
            ifid_pc1_q   <= pc_inc;
            ifid_inst_q  <= imem.imem_data;
            ifid_valid_q <= 1'b1;
            if (!is_halt(imem.imem_data)) begin
                pc_q <= pc_inc;
            end
        end
    end

    assign imem.imem_addr = pc_q;
    assign PC             = ifid_pc_q;
    assign PCPlus1        = ifid_pc1_q;
    assign inst           = ifid_inst_q;
    assign inst_valid     = ifid_valid_q;

`ifdef FETCH_PERF_EN
    logic bubble_ev;

    // Bubbles come from redirects and from stalls while still running.
    assign bubble_ev = redirect_valid || (stall && state_q == FS_RUN);

    fetch_perf_counters u_perf (
        .clk          (clk),
        .rst          (rst),
        .fetch_ev     (fetch_en),
        .bubble_ev    (bubble_ev),
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stimulus
// against a behavioural model. Two instances: RESET_PC=0000 and RESET_PC=FFFF.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        halt_en;
    logic [15:0] halt_addr;
    logic [15:0] halt_word;
    logic [15:0] mem_xor;

    logic [15:0] pc_o    [2];
    logic [15:0] p1_o    [2];
    logic [15:0] inst_o  [2];
    logic        valid_o [2];
    logic        halt_o  [2];
`ifdef FETCH_PERF_EN
    logic [31:0] fc_o    [2];
    logic [31:0] bc_o    [2];
`endif

    int n_tests;
    int n_fail;

    // Behavioural model state, one slot per instance.
    logic [15:0] rst_val [2];
    logic [15:0] m_pc    [2];
    logic [15:0] m_pcr   [2];
    logic [15:0] m_p1    [2];
    logic [15:0] m_inst  [2];
    logic        m_v     [2];
    logic        m_h     [2];
    logic [31:0] m_fc    [2];
    logic [31:0] m_bc    [2];

    fetch_stage_if bus0 ();
    fetch_stage_if bus1 ();

    // Instruction memory: 16'hC000+addr, optionally scrambled, with one halt slot.
    function automatic logic [15:0] imem_fn(input logic [15:0] a, input logic he,
                                            input logic [15:0] ha, input logic [15:0] hw,
                                            input logic [15:0] mx);
        if (he && a == ha) return hw;
        return (16'hC000 + a) ^ mx;
    endfunction

    assign bus0.imem_data = imem_fn(bus0.imem_addr, halt_en, halt_addr, halt_word, mem_xor);
    assign bus1.imem_data = imem_fn(bus1.imem_addr, halt_en, halt_addr, halt_word, mem_xor);

    fetch_stage #(.RESET_PC(16'h0000)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redir),
        .redirect_pc    (rpc),
        .imem           (bus0),
        .PC             (pc_o[0]),
        .PCPlus1        (p1_o[0]),
        .inst           (inst_o[0]),
        .inst_valid     (valid_o[0]),
        .halted         (halt_o[0])
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fc_o[0]),
        .bubble_count   (bc_o[0])
`endif
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redir),
        .redirect_pc    (rpc),
        .imem           (bus1),
        .PC             (pc_o[1]),
        .PCPlus1        (p1_o[1]),
        .inst           (inst_o[1]),
        .inst_valid     (valid_o[1]),
        .halted         (halt_o[1])
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fc_o[1]),
        .bubble_count   (bc_o[1])
`endif
    );

    logic [65:0] obs [2];
    assign obs[0] = {bus0.imem_addr, pc_o[0], p1_o[0], inst_o[0], valid_o[0], halt_o[0]};
    assign obs[1] = {bus1.imem_addr, pc_o[1], p1_o[1], inst_o[1], valid_o[1], halt_o[1]};

    function automatic logic [65:0] expv(input int k);
        return {m_pc[k], m_pcr[k], m_p1[k], m_inst[k], m_v[k], m_h[k]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one edge of the specified behaviour to the model, then advance the DUTs.
    task automatic step();
        logic [15:0] w;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] = rst_val[k];  m_pcr[k] = rst_val[k];  m_p1[k] = rst_val[k] + 16'd1;
                m_inst[k] = 16'h1000;  m_v[k] = 1'b0;  m_h[k] = 1'b0;
                m_fc[k] = 0;  m_bc[k] = 0;
            end else if (redir) begin
                m_pc[k] = rpc;  m_inst[k] = 16'h1000;  m_v[k] = 1'b0;  m_h[k] = 1'b0;
                m_bc[k] = m_bc[k] + 1;
            end else if (stall) begin
                if (!m_h[k]) m_bc[k] = m_bc[k] + 1;
            end else if (!m_h[k]) begin
                w = imem_fn(m_pc[k], halt_en, halt_addr, halt_word, mem_xor);
                m_pcr[k] = m_pc[k];  m_p1[k] = m_pc[k] + 16'd1;  m_inst[k] = w;  m_v[k] = 1'b1;
                m_fc[k] = m_fc[k] + 1;
                if (w[15:12] == 4'b0000) m_h[k] = 1'b1;
                else m_pc[k] = m_pc[k] + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;  stall = 1'b1;  redir = 1'b1;  rpc = 16'h1234;
        step();
        rst = 1'b0;  stall = 1'b0;  redir = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs[k] !== expv(k)) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h, expected %h", k, obs[k], expv(k));
            end
        end
        n_tests++;
        if ({pc_o[0], p1_o[0], inst_o[0], valid_o[0], halt_o[0]} !== {16'h0, 16'h1, 16'h1000, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_const: got PC=%h PCPlus1=%h inst=%h v=%b h=%b", pc_o[0],
                     p1_o[0], inst_o[0], valid_o[0], halt_o[0]);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({pc_o[0], p1_o[0], inst_o[0], valid_o[0]} !==
                {16'(i), 16'(i + 1), 16'hC000 + 16'(i), 1'b1}) begin
                n_fail++;
                $display("FAIL seq edge%0d: got PC=%h PCPlus1=%h inst=%h v=%b", i + 1, pc_o[0],
                         p1_o[0], inst_o[0], valid_o[0]);
            end
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== expv(k)) begin
                    n_fail++;
                    $display("FAIL seq_model dut%0d: got %h, expected %h", k, obs[k], expv(k));
                end
            end
        end
        // dut1 started at FFFF: edge1 FFFF/0000, edge2 PC 0000.
        n_tests++;
        if (pc_o[1] !== 16'h0001) begin
            n_fail++;
            $display("FAIL wrap_seq: got PC=%h, expected 0001", pc_o[1]);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_tests++;
        if ({pc_o[1], p1_o[1]} !== {16'hFFFF, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_first: got PC=%h PCPlus1=%h, expected FFFF 0000", pc_o[1], p1_o[1]);
        end
        step();
        n_tests++;
        if ({pc_o[1], p1_o[1], inst_o[1]} !== {16'h0000, 16'h0001, 16'hC000}) begin
            n_fail++;
            $display("FAIL wrap_second: got PC=%h PCPlus1=%h inst=%h", pc_o[1], p1_o[1], inst_o[1]);
        end
        step();  // dut0 now has pc_q=3
    endtask

    task automatic test_stall();
        step();
        step();  // dut0 pc_q=5, IF/ID holds address 4
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({bus0.imem_addr, pc_o[0], inst_o[0], valid_o[0]} !== {16'h5, 16'h4, 16'hC004, 1'b1}) begin
                n_fail++;
                $display("FAIL stall%0d: got addr=%h PC=%h inst=%h", i, bus0.imem_addr, pc_o[0],
                         inst_o[0]);
            end
        end
        stall = 1'b0;
        step();
        n_tests++;
        if ({pc_o[0], inst_o[0]} !== {16'h5, 16'hC005}) begin
            n_fail++;
            $display("FAIL stall_release: got PC=%h inst=%h, expected 0005 C005", pc_o[0], inst_o[0]);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1;  redir = 1'b1;  rpc = 16'h0040;
        step();
        stall = 1'b0;  redir = 1'b0;
        n_tests++;
        if ({bus0.imem_addr, inst_o[0], valid_o[0]} !== {16'h0040, 16'h1000, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect: got addr=%h inst=%h v=%b", bus0.imem_addr, inst_o[0], valid_o[0]);
        end
        step();
        n_tests++;
        if ({pc_o[0], inst_o[0], valid_o[0]} !== {16'h0040, 16'hC040, 1'b1}) begin
            n_fail++;
            $display("FAIL redirect_fetch: got PC=%h inst=%h v=%b", pc_o[0], inst_o[0], valid_o[0]);
        end
    endtask

    task automatic test_halt();
        halt_en = 1'b1;  halt_addr = 16'h0007;  halt_word = 16'h0ABC;
        redir = 1'b1;  rpc = 16'h0007;
        step();
        redir = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
            n_tests++;
            if ({bus0.imem_addr, pc_o[0], inst_o[0], halt_o[0]} !== {16'h7, 16'h7, 16'h0ABC, 1'b1}) begin
                n_fail++;
                $display("FAIL halt_hold%0d: got addr=%h PC=%h inst=%h h=%b", i, bus0.imem_addr,
                         pc_o[0], inst_o[0], halt_o[0]);
            end
            stall = 1'($urandom_range(0, 1));
        end
        redir = 1'b1;  rpc = 16'h0020;
        step();
        redir = 1'b0;  stall = 1'b0;
        n_tests++;
        if ({halt_o[0], valid_o[0], bus0.imem_addr} !== {2'b00, 16'h0020}) begin
            n_fail++;
            $display("FAIL halt_exit: got h=%b v=%b addr=%h", halt_o[0], valid_o[0], bus0.imem_addr);
        end
        step();
        n_tests++;
        if ({pc_o[0], inst_o[0]} !== {16'h0020, 16'hC020}) begin
            n_fail++;
            $display("FAIL halt_resume: got PC=%h inst=%h", pc_o[0], inst_o[0]);
        end
    endtask

    task automatic test_reset_in_halt();
        redir = 1'b1;  rpc = 16'h0007;
        step();
        redir = 1'b0;
        step();
        rst = 1'b1;  stall = 1'b1;
        step();
        rst = 1'b0;  stall = 1'b0;  halt_en = 1'b0;
        n_tests++;
        if ({pc_o[0], inst_o[0], valid_o[0], halt_o[0], pc_o[1], p1_o[1], inst_o[1]} !==
            {16'h0, 16'h1000, 2'b00, 16'hFFFF, 16'h0000, 16'h1000}) begin
            n_fail++;
            $display("FAIL reset_halted: got PC0=%h inst0=%h v=%b h=%b PC1=%h P1=%h inst1=%h",
                     pc_o[0], inst_o[0], valid_o[0], halt_o[0], pc_o[1], p1_o[1], inst_o[1]);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;  redir = 1'b1;  rpc = 16'h0100;
        step();
        redir = 1'b0;
        n_tests++;
        if ({fc_o[0], bc_o[0]} !== {32'd4, 32'd3}) begin
            n_fail++;
            $display("FAIL perf: got fetch=%0d bubble=%0d, expected 4 3", fc_o[0], bc_o[0]);
        end
    endtask
`endif

    task automatic test_random();
        mem_xor = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 25);
            redir = ($urandom_range(0, 99) < 10);
            rpc   = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
            halt_en   = ($urandom_range(0, 3) == 0);
            halt_addr = 16'($urandom_range(0, 15));
            halt_word = {4'b0000, 12'($urandom)};
            step();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== expv(k)) begin
                    n_fail++;
                    $display("FAIL random%0d dut%0d: got %h, expected %h", i, k, obs[k], expv(k));
                end
`ifdef FETCH_PERF_EN
                n_tests++;
                if ({fc_o[k], bc_o[k]} !== {m_fc[k], m_bc[k]}) begin
                    n_fail++;
                    $display("FAIL random_perf%0d dut%0d: got %0d/%0d, expected %0d/%0d", i, k,
                             fc_o[k], bc_o[k], m_fc[k], m_bc[k]);
                end
`endif
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_val[0] = 16'h0000;
        rst_val[1] = 16'hFFFF;
        rst = 1'b0;  stall = 1'b0;  redir = 1'b0;  rpc = 16'h0;
        halt_en = 1'b0;  halt_addr = 16'h0;  halt_word = 16'h0;  mem_xor = 16'h0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_in_halt();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of decode.
- Owns the program counter and drives the instruction-memory address.
- Holds the IF/ID pipeline register, which supplies decode's PC, PCPlus1 and inst inputs.
- Handles sequential fetch, hazard stalls, branch/jump redirects and halt hold-off, with a small RUN/HALTED state machine.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (word address).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hazard-unit hold; freezes PC and IF/ID.
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  16  target word address for the redirect.
- imem_addr  out  16  instruction-memory address; equals current PC register, combinational.
- imem_data  in  16  instruction word, combinational read of imem_addr in the same cycle.
- PC  out  16  IF/ID register: address of inst.
- PCPlus1  out  16  IF/ID register: PC+1, wrapping modulo 2^16.
- inst  out  16  IF/ID register: instruction to decode.
- inst_valid  out  1  IF/ID holds a real fetched instruction (0 = bubble).
- halted  out  1  state machine is in HALTED.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at the edge), regardless of state or other inputs:
  - pc_q=RESET_PC; PC=RESET_PC; PCPlus1=RESET_PC+1.
  - inst=BUBBLE_INST (16'h1000); inst_valid=0; halted=0; state=RUN.
  - Reset mid-stall, mid-halt or mid-redirect takes effect in that same cycle.
- BUBBLE_INST has opcode 0001 with bit15=0. Decode treats it as no write, no memory access, no halt and no branch.
- Per-edge priority: rst > redirect_valid > stall > HALTED hold > normal fetch.
- Redirect, in any state:
  - pc_q<=redirect_pc; IF/ID<=bubble (PC/PCPlus1 unchanged, inst=BUBBLE_INST, inst_valid=0).
  - state<=RUN. Redirect overrides a simultaneous stall and exits HALTED, because a halt fetched on a wrong path must be squashed.
- Stall (no redirect): pc_q, PC, PCPlus1, inst, inst_valid and state all hold. imem_addr stays at pc_q.
- Normal fetch in RUN (no stall, no redirect):
  - IF/ID<={pc_q, pc_q+1, imem_data}; inst_valid<=1; pc_q<=pc_q+1.
  - 16'hFFFF wraps to 16'h0000; PCPlus1 also wraps.
  - Latency: an instruction at address A appears on inst one edge after pc_q==A.
- Halt entry:
  - If a normal fetch latches imem_data[15:12]==4'b0000, state<=HALTED in that edge.
  - pc_q is NOT incremented; it stays at the halt address.
- HALTED (no redirect, no stall): pc_q and IF/ID hold, so decode keeps seeing the halt instruction. halted=1 from the edge of entry. Stall has no visible effect.
- States: RUN -> HALTED on halt fetch. HALTED -> RUN only on redirect or reset. No other transitions.
- All outputs are registered except imem_addr.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs fetch_count[31:0] (increments on each normal fetch edge) and bubble_count[31:0] (increments on each redirect edge and on each stalled edge in RUN).
  - Both clear on rst and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared cpu package holds:
  - OP_HALT=4'b0000 and the opcode field position [15:12].
  - BUBBLE_INST=16'h1000.
  - fetch_state_t enum {FS_RUN, FS_HALTED}.
  - Shared by decode and the hazard unit.
- One natural sub-module: fetch_perf_counters, instantiated only under FETCH_PERF_EN. The core stage remains a single module.

Test Plan:
- Reset release, imem returns 16'hC000+addr: edges 1..3 give inst=C000/C001/C002, PC=0/1/2, PCPlus1=1/2/3, inst_valid=1; outputs are bubble before the first edge.
- Stall high for 2 cycles at pc_q=5: PC/inst frozen at address 4 both cycles, imem_addr=5; the next normal edge latches address 5.
- Redirect to 16'h0040 while stall=1: next edge pc_q=0x40, inst=16'h1000, inst_valid=0; the following edge latches address 0x40.
- imem_data=16'h0ABC at address 7: halted=1; PC=7 and inst=0ABC held for 10+ cycles; a later redirect to 0x20 clears halted and resumes fetch at 0x20.
- RESET_PC=16'hFFFF: first fetch PC=FFFF, PCPlus1=0000, then PC=0000; asserting rst during HALTED returns to RESET_PC with a bubble.
- With FETCH_PERF_EN: 4 fetches, 2 stall cycles and 1 redirect give fetch_count=4 and bubble_count=3.
